// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : VGA timing generator with sync/video alignment pipeline
// Revision     : 1.0
// ============================================================================
module vga_sync_gen #(
  parameter int   TOTAL_COLS    = 800,
  parameter int   TOTAL_ROWS    = 525,
  parameter int   ACTIVE_COLS   = 640,
  parameter int   ACTIVE_ROWS   = 480,
  parameter int   H_FRONT_PORCH = 16,
  parameter int   H_SYNC_PULSE  = 96,
  parameter int   H_BACK_PORCH  = 48,
  parameter int   V_FRONT_PORCH = 10,
  parameter int   V_SYNC_PULSE  = 2,
  parameter int   V_BACK_PORCH  = 33,
  parameter int   VIDEO_LATENCY = 2,
  parameter logic SYNC_ACTIVE   = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [9:0] c_LAST_COL    = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] c_LAST_ROW    = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] c_ACTIVE_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] c_ACTIVE_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] c_HS_START    = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] c_HS_END      = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [9:0] c_VS_START    = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] c_VS_END      = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE - 1);

  generate
    if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH != TOTAL_COLS) begin : g_h_timing_bad
      $fatal(1, "vga_sync_gen: horizontal timing does not sum to TOTAL_COLS");
    end
    if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH != TOTAL_ROWS) begin : g_v_timing_bad
      $fatal(1, "vga_sync_gen: vertical timing does not sum to TOTAL_ROWS");
    end
    if (VIDEO_LATENCY < 1) begin : g_latency_bad
      $fatal(1, "vga_sync_gen: VIDEO_LATENCY must be at least 1");
    end
  endgenerate

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [9:0] r_col;
  logic [9:0] r_row;
  logic       w_col_last;
  logic       w_row_last;
  logic       w_running;
  logic       w_hsync_raw;
  logic       w_vsync_raw;

  logic [VIDEO_LATENCY-1:0] r_hs_pipe;
  logic [VIDEO_LATENCY-1:0] r_vs_pipe;
  logic [VIDEO_LATENCY-1:0] r_act_pipe;

  assign w_col_last  = (r_col == c_LAST_COL);
  assign w_row_last  = (r_row == c_LAST_ROW);
  assign o_Col_Count = r_col;
  assign o_Row_Count = r_row;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  w_next_state = i_Enable ? c_RUN : c_IDLE;
      c_RUN:   w_next_state = i_Enable ? c_RUN : c_DRAIN;
      c_DRAIN: begin
        // Re-enable wins so a late request still continues seamlessly into the next frame
        if (i_Enable)                      w_next_state = c_RUN;
        else if (w_col_last && w_row_last) w_next_state = c_IDLE;
        else                               w_next_state = c_DRAIN;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_running     = (r_state == c_RUN) || (r_state == c_DRAIN);
    o_Active      = w_running && (r_col < c_ACTIVE_COLS) && (r_row < c_ACTIVE_ROWS);
    o_Frame_Start = w_running && (r_col == 10'd0) && (r_row == 10'd0);
    w_hsync_raw   = (w_running && (r_col >= c_HS_START) && (r_col <= c_HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vsync_raw   = (w_running && (r_row >= c_VS_START) && (r_row <= c_VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (!w_running) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_col_last) begin
      r_col <= '0;
      r_row <= w_row_last ? 10'd0 : r_row + 10'd1;
    end else begin
      r_col <= r_col + 10'd1;
    end
  end

  // Delay sync/active so they meet the pixel colour that arrives VIDEO_LATENCY cycles late
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_hs_pipe   <= {VIDEO_LATENCY{~SYNC_ACTIVE}};
      r_vs_pipe   <= {VIDEO_LATENCY{~SYNC_ACTIVE}};
      r_act_pipe  <= '0;
      o_HSync     <= ~SYNC_ACTIVE;
      o_VSync     <= ~SYNC_ACTIVE;
      o_Red_Video <= 4'd0;
      o_Grn_Video <= 4'd0;
      o_Blu_Video <= 4'd0;
    end else begin
      r_hs_pipe[0]  <= w_hsync_raw;
      r_vs_pipe[0]  <= w_vsync_raw;
      r_act_pipe[0] <= o_Active;
      for (int i = 1; i < VIDEO_LATENCY; i++) begin
        r_hs_pipe[i]  <= r_hs_pipe[i-1];
        r_vs_pipe[i]  <= r_vs_pipe[i-1];
        r_act_pipe[i] <= r_act_pipe[i-1];
      end
      o_HSync     <= r_hs_pipe[VIDEO_LATENCY-1];
      o_VSync     <= r_vs_pipe[VIDEO_LATENCY-1];
      o_Red_Video <= r_act_pipe[VIDEO_LATENCY-1] ? i_Red_Video : 4'd0;
      o_Grn_Video <= r_act_pipe[VIDEO_LATENCY-1] ? i_Grn_Video : 4'd0;
      o_Blu_Video <= r_act_pipe[VIDEO_LATENCY-1] ? i_Blu_Video : 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates the VGA timing that the Pong display path consumes: column/row counters, HSync/VSync pulses with front/back porches, an active-video flag and a frame-start strobe.
- Accepts pixel colour from the game logic a fixed number of cycles after each count.
- Blanks the pixel outside the active area and emits HSync/VSync/RGB aligned for the VGA connector.
- This is the transmit side of the sync interface that the game top-level receives.

Parameters:
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, pixels between active end and HSync start
- H_SYNC_PULSE, 96, HSync width in pixels
- H_BACK_PORCH, 48, pixels between HSync end and line end
- V_FRONT_PORCH, 10, lines between active end and VSync start
- V_SYNC_PULSE, 2, VSync width in lines
- V_BACK_PORCH, 33, lines between VSync end and frame end
- VIDEO_LATENCY, 2, cycles (>=1) from count output to matching i_Red/Grn/Blu
- SYNC_ACTIVE, 0, asserted level of HSync/VSync

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Enable  in  1  run request
- i_Red_Video  in  4  pixel red, valid VIDEO_LATENCY cycles after its count
- i_Grn_Video  in  4  pixel green, same timing
- i_Blu_Video  in  4  pixel blue, same timing
- o_Col_Count  out  10  current column
- o_Row_Count  out  10  current row
- o_Active  out  1  current count is inside the visible area
- o_Frame_Start  out  1  one-cycle pulse at (0,0) while running
- o_HSync  out  1  horizontal sync, aligned to o_*_Video
- o_VSync  out  1  vertical sync, aligned to o_*_Video
- o_Red_Video  out  4  blanked red
- o_Grn_Video  out  4  blanked green
- o_Blu_Video  out  4  blanked blue

Behaviour:
- Reset (async, any time):
  - state=IDLE, counters=0, o_Active=0, o_Frame_Start=0
  - o_HSync=o_VSync=~SYNC_ACTIVE, RGB=0
  - all delay-pipeline stages cleared to inactive/0
- States:
  - IDLE:
    - counters held at 0, o_Active=0, o_Frame_Start=0
    - i_Enable=1 sampled -> RUN; the first RUN cycle presents (0,0) with o_Frame_Start=1
  - RUN:
    - col increments every cycle and wraps TOTAL_COLS-1 -> 0
    - on col wrap, row increments and wraps TOTAL_ROWS-1 -> 0
    - i_Enable=0 sampled -> DRAIN
  - DRAIN:
    - counts identically to RUN
    - i_Enable=1 -> RUN with no discontinuity
    - at (TOTAL_COLS-1, TOTAL_ROWS-1) -> IDLE; counters become 0 and no o_Frame_Start is issued
- o_Frame_Start: 1 exactly in cycles where state is RUN/DRAIN and count=(0,0).
- o_Active: state is RUN/DRAIN and col<ACTIVE_COLS and row<ACTIVE_ROWS.
- Raw HSync (per count):
  - SYNC_ACTIVE when col in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_PULSE-1] and not IDLE
  - ~SYNC_ACTIVE otherwise
- Raw VSync: same rule applied to row with the V_* parameters.
- Alignment pipeline:
  - raw HSync, raw VSync and o_Active are delayed VIDEO_LATENCY cycles
  - a final register stage drives the outputs
  - o_HSync/o_VSync/o_*_Video for the count shown at cycle n appear at cycle n+VIDEO_LATENCY+1
  - video output = delayed active ? i_*_Video : 0, registered
- Boundary conditions:
  - the last line's wrap to (0,0) is seamless in RUN; no gap cycle
  - after entering IDLE, the pipeline drains its remaining blanking entries, then outputs stay inactive
- Elaboration check: ACTIVE+FRONT+SYNC+BACK must equal TOTAL on each axis. A mismatch is a fatal error.

Test Plan:
- Reset held, i_Enable=1, i_Red=F -> all outputs at reset values; o_HSync=o_VSync=1 (defaults).
- Reset release, i_Enable=1, defaults -> o_Frame_Start pulses every 420000 cycles; o_Col_Count runs 0..799, o_Row_Count runs 0..524.
- HSync timing with VIDEO_LATENCY=2:
  - o_HSync=0 for exactly 96 cycles per line
  - its falling edge is 3 cycles after o_Col_Count=656
  - o_VSync=0 during rows 490-491 only, shifted by the same 3 cycles
- i_Red/Grn/Blu held at F -> outputs F for exactly 640 consecutive cycles on each of rows 0-479, 0 elsewhere; rows 480-524 are fully 0.
- i_Enable dropped at row 100 -> counting continues to (799,524), then IDLE with counters 0 and no further o_Frame_Start; re-raising at row 300 in DRAIN gives no glitch in the count sequence.
- i_Reset pulsed mid-line at col 400 -> outputs return to reset values immediately (asynchronously); after release with i_Enable=1, the first cycle in RUN shows (0,0) with o_Frame_Start=1.
